fizzbuzz_scheduler: RTL and testbench

//  Sequences a programmable FizzBuzz event stream for downstream consumers.

---
 rtl/fizzbuzz_scheduler_if.sv | 48 ++++
 rtl/fizzbuzz_scheduler.sv | 149 ++++++++++++++
 tb/tb_fizzbuzz_scheduler.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fizzbuzz_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : fizzbuzz_scheduler_if
// Description : Config, control and token-stream bundle for fizzbuzz_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface fizzbuzz_scheduler_if #(
    parameter int DATA_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DATA_W-1:0] cfg_fizz;
    logic [DATA_W-1:0] cfg_buzz;
    logic [DATA_W-1:0] cfg_max;
    logic              cfg_err;
    logic              start;
    logic              stop;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_index;
    logic              out_fizz;
    logic              out_buzz;
    logic              out_fizzbuzz;
`ifdef FIZZBUZZ_PAUSE_EN
    logic              pause;
`endif

    modport master (
`ifdef FIZZBUZZ_PAUSE_EN
        output pause,
`endif
        output cfg_valid, cfg_fizz, cfg_buzz, cfg_max, start, stop, out_ready,
        input  cfg_ready, cfg_err, busy, done, out_valid, out_index,
               out_fizz, out_buzz, out_fizzbuzz
    );

    modport slave (
`ifdef FIZZBUZZ_PAUSE_EN
        input  pause,
`endif
        input  cfg_valid, cfg_fizz, cfg_buzz, cfg_max, start, stop, out_ready,
        output cfg_ready, cfg_err, busy, done, out_valid, out_index,
               out_fizz, out_buzz, out_fizzbuzz
    );
endinterface
`default_nettype wire

// File: rtl/fizzbuzz_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fizzbuzz_scheduler
// Description : Programmable FizzBuzz token sequencer using residue counters.
//               Optional PAUSE state enabled by macro FIZZBUZZ_PAUSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fizzbuzz_scheduler #(
    parameter int DATA_W   = 8,
    parameter int DEF_FIZZ = 3,
    parameter int DEF_BUZZ = 5,
    parameter int DEF_MAX  = 100
) (
    input wire                   clk,
    input wire                   reset,
    fizzbuzz_scheduler_if.slave  bus
);

    localparam logic [DATA_W-1:0] c_zero     = '0;
    localparam logic [DATA_W-1:0] c_one      = DATA_W'(1);
    localparam logic [DATA_W-1:0] c_def_fizz = DATA_W'(DEF_FIZZ);
    localparam logic [DATA_W-1:0] c_def_buzz = DATA_W'(DEF_BUZZ);
    localparam logic [DATA_W-1:0] c_def_max  = DATA_W'(DEF_MAX);

`ifdef FIZZBUZZ_PAUSE_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2, ST_PAUSE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_fizz_div;
    logic [DATA_W-1:0] r_buzz_div;
    logic [DATA_W-1:0] r_max;
    logic [DATA_W-1:0] r_index;
    logic [DATA_W-1:0] r_res_fizz;
    logic [DATA_W-1:0] r_res_buzz;
    logic              r_cfg_err;

    logic              w_cfg_ready;
    logic              w_cfg_fire;
    logic              w_cfg_bad;
    logic              w_cfg_load;
    logic              w_start_go;
    logic              w_out_valid;
    logic              w_beat;
    logic              w_last;
    logic              w_busy;
    logic [DATA_W-1:0] w_fizz_src;
    logic [DATA_W-1:0] w_buzz_src;
    logic [DATA_W-1:0] w_res_fizz_p1;
    logic [DATA_W-1:0] w_res_buzz_p1;

    // Residue of index 1 is 0 for a divisor of 1, otherwise 1.
    function automatic logic [DATA_W-1:0] f_res_init(input logic [DATA_W-1:0] div);
        return (div == c_one) ? c_zero : c_one;
    endfunction

    assign w_cfg_ready   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_cfg_fire    = bus.cfg_valid && w_cfg_ready;
    assign w_cfg_bad     = (bus.cfg_fizz == c_zero) || (bus.cfg_buzz == c_zero) ||
                           (bus.cfg_max == c_zero);
    assign w_cfg_load    = w_cfg_fire && !w_cfg_bad;
    assign w_start_go    = w_cfg_ready && bus.start && !bus.stop;
    assign w_out_valid   = (r_state == ST_RUN);
    assign w_beat        = w_out_valid && bus.out_ready;
    assign w_last        = (r_index == r_max);
    // A start coinciding with an accepted config runs with the new divisors.
    assign w_fizz_src    = w_cfg_load ? bus.cfg_fizz : r_fizz_div;
    assign w_buzz_src    = w_cfg_load ? bus.cfg_buzz : r_buzz_div;
    assign w_res_fizz_p1 = r_res_fizz + c_one;
    assign w_res_buzz_p1 = r_res_buzz + c_one;
`ifdef FIZZBUZZ_PAUSE_EN
    assign w_busy        = (r_state == ST_RUN) || (r_state == ST_PAUSE);
`else
    assign w_busy        = (r_state == ST_RUN);
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_go) w_state_nxt = ST_RUN;
            end
            ST_DONE: begin
                if (w_start_go)      w_state_nxt = ST_RUN;
                else if (w_cfg_load) w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.stop)              w_state_nxt = ST_IDLE;
                else if (w_beat && w_last) w_state_nxt = ST_DONE;
`ifdef FIZZBUZZ_PAUSE_EN
                else if (bus.pause)        w_state_nxt = ST_PAUSE;
`endif
            end
`ifdef FIZZBUZZ_PAUSE_EN
            ST_PAUSE: begin
                if (bus.stop)        w_state_nxt = ST_IDLE;
                else if (!bus.pause) w_state_nxt = ST_RUN;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_fizz_div <= c_def_fizz;
            r_buzz_div <= c_def_buzz;
            r_max      <= c_def_max;
            r_index    <= c_one;
            r_res_fizz <= f_res_init(c_def_fizz);
            r_res_buzz <= f_res_init(c_def_buzz);
            r_cfg_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_err <= w_cfg_fire && w_cfg_bad;
            if (w_cfg_load) begin
                r_fizz_div <= bus.cfg_fizz;
                r_buzz_div <= bus.cfg_buzz;
                r_max      <= bus.cfg_max;
            end
            if (w_start_go) begin
                r_index    <= c_one;
                r_res_fizz <= f_res_init(w_fizz_src);
                r_res_buzz <= f_res_init(w_buzz_src);
            end else if (w_beat && !w_last) begin
                // Index holds at the limit so it can never overflow.
                r_index    <= r_index + c_one;
                r_res_fizz <= (w_res_fizz_p1 == r_fizz_div) ? c_zero : w_res_fizz_p1;
                r_res_buzz <= (w_res_buzz_p1 == r_buzz_div) ? c_zero : w_res_buzz_p1;
            end
        end
    end

    assign bus.cfg_ready    = w_cfg_ready;
    assign bus.cfg_err      = r_cfg_err;
    assign bus.busy         = w_busy;
    assign bus.done         = (r_state == ST_DONE);
    assign bus.out_valid    = w_out_valid;
    assign bus.out_index    = r_index;
    assign bus.out_fizz     = w_out_valid && (r_res_fizz == c_zero);
    assign bus.out_buzz     = w_out_valid && (r_res_buzz == c_zero);
    assign bus.out_fizzbuzz = w_out_valid && (r_res_fizz == c_zero) && (r_res_buzz == c_zero);

endmodule
`default_nettype wire

// File: tb/tb_fizzbuzz_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fizzbuzz_scheduler
// Description : Self-checking bench for fizzbuzz_scheduler (token scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fizzbuzz_scheduler;

    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] idx;
        logic          f;
        logic          b;
        logic          fb;
    } tok_t;

    typedef struct {
        logic [DW-1:0] fizz;
        logic [DW-1:0] buzz;
        logic [DW-1:0] max;
        logic          exp_err;
        logic          exp_done;
    } cfg_vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fizzbuzz_scheduler_if #(.DATA_W(DW)) ifc ();

    fizzbuzz_scheduler #(
        .DATA_W  (DW),
        .DEF_FIZZ(3),
        .DEF_BUZZ(5),
        .DEF_MAX (100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    tok_t sb[$];
    int   m_fizz = 3;
    int   m_buzz = 5;
    int   m_max  = 100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic tok_t model_tok(input int i);
        tok_t t;
        t.idx = DW'(i);
        t.f   = (i % m_fizz) == 0;
        t.b   = (i % m_buzz) == 0;
        t.fb  = t.f && t.b;
        return t;
    endfunction

    task automatic push_run();
        for (int i = 1; i <= m_max; i++) sb.push_back(model_tok(i));
    endtask

    // One clock: score any handshake that the coming edge will accept.
    task automatic tick();
        tok_t got;
        tok_t exp;
        @(negedge clk);
        if (!reset && ifc.out_valid && ifc.out_ready) begin
            got = {ifc.out_index, ifc.out_fizz, ifc.out_buzz, ifc.out_fizzbuzz};
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat: unexpected token idx %0d", ifc.out_index);
            end else begin
                exp = sb.pop_front();
                check("beat", 32'(got), 32'(exp));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        push_run();
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        check("first_valid", 32'(ifc.out_valid), 1);
        check("first_index", 32'(ifc.out_index), 1);
    endtask

    task automatic run_to_done(input logic exp_done);
        int k = 0;
        while (sb.size() != 0 && k < 2000) begin
            tick();
            k++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_timeout: %0d tokens outstanding, expected 0", sb.size());
            sb.delete();
        end
        check("done_after_last", 32'(ifc.done), 32'(exp_done));
        check("valid_after_last", 32'(ifc.out_valid), 0);
        check("busy_after_last", 32'(ifc.busy), 0);
    endtask

    task automatic wait_idx(input int target);
        int k = 0;
        while (!(ifc.out_valid && ifc.out_index == DW'(target)) && k < 1000) begin
            tick();
            k++;
        end
        if (k >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_idx: index %0d never presented, last %0d", target, ifc.out_index);
        end
    endtask

    cfg_vec_t vecs[6];

    initial begin
        vecs[0] = '{fizz: 8'd0, buzz: 8'd5, max: 8'd100, exp_err: 1'b1, exp_done: 1'b0};
        vecs[1] = '{fizz: 8'd3, buzz: 8'd0, max: 8'd100, exp_err: 1'b1, exp_done: 1'b1};
        vecs[2] = '{fizz: 8'd3, buzz: 8'd5, max: 8'd0,   exp_err: 1'b1, exp_done: 1'b1};
        vecs[3] = '{fizz: 8'd2, buzz: 8'd7, max: 8'd14,  exp_err: 1'b0, exp_done: 1'b0};
        vecs[4] = '{fizz: 8'd1, buzz: 8'd1, max: 8'd5,   exp_err: 1'b0, exp_done: 1'b0};
        vecs[5] = '{fizz: 8'd4, buzz: 8'd6, max: 8'd255, exp_err: 1'b0, exp_done: 1'b0};

        reset         = 1'b1;
        ifc.cfg_valid = 1'b0;
        ifc.cfg_fizz  = '0;
        ifc.cfg_buzz  = '0;
        ifc.cfg_max   = '0;
        ifc.start     = 1'b0;
        ifc.stop      = 1'b0;
        ifc.out_ready = 1'b0;
`ifdef FIZZBUZZ_PAUSE_EN
        ifc.pause     = 1'b0;
`endif
        repeat (3) tick();

        // Reset state
        check("rst_valid", 32'(ifc.out_valid), 0);
        check("rst_busy", 32'(ifc.busy), 0);
        check("rst_done", 32'(ifc.done), 0);
        check("rst_cfg_err", 32'(ifc.cfg_err), 0);
        check("rst_index", 32'(ifc.out_index), 1);
        check("rst_flags", 32'({ifc.out_fizz, ifc.out_buzz, ifc.out_fizzbuzz}), 0);
        check("rst_cfg_ready", 32'(ifc.cfg_ready), 1);
        reset = 1'b0;

        // Default 3/5/100 run with a free-flowing sink
        ifc.out_ready = 1'b1;
        start_run();
        check("run_busy", 32'(ifc.busy), 1);
        check("run_cfg_ready", 32'(ifc.cfg_ready), 0);
        run_to_done(1'b1);
        check("done_cfg_ready", 32'(ifc.cfg_ready), 1);

        // Backpressure at index 6; a start during RUN is ignored
        start_run();
        wait_idx(6);
        ifc.out_ready = 1'b0;
        ifc.start     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            ifc.start = 1'b0;
            check("stall_index", 32'(ifc.out_index), 6);
            check("stall_fizz", 32'(ifc.out_fizz), 1);
            check("stall_valid", 32'(ifc.out_valid), 1);
        end
        ifc.out_ready = 1'b1;
        run_to_done(1'b1);

        // Stop together with a handshake at index 9
        start_run();
        wait_idx(9);
        ifc.stop = 1'b1;
        tick();
        ifc.stop = 1'b0;
        check("stop_consumed_next", 32'(sb[0].idx), 10);
        check("stop_busy", 32'(ifc.busy), 0);
        check("stop_valid", 32'(ifc.out_valid), 0);
        check("stop_done", 32'(ifc.done), 0);
        sb.delete();
        tick();
        check("idle_valid", 32'(ifc.out_valid), 0);
        start_run();
        wait_idx(3);
        ifc.stop = 1'b1;
        tick();
        ifc.stop = 1'b0;
        sb.delete();
        ifc.start = 1'b1;
        ifc.stop  = 1'b1;
        tick();
        ifc.start = 1'b0;
        ifc.stop  = 1'b0;
        check("stop_start_idle_busy", 32'(ifc.busy), 0);

        // Config table: rejected configs keep old values, accepted ones apply
        for (int i = 0; i < 6; i++) begin
            ifc.cfg_fizz  = vecs[i].fizz;
            ifc.cfg_buzz  = vecs[i].buzz;
            ifc.cfg_max   = vecs[i].max;
            ifc.cfg_valid = 1'b1;
            tick();
            ifc.cfg_valid = 1'b0;
            check($sformatf("cfg_err_%0d", i), 32'(ifc.cfg_err), 32'(vecs[i].exp_err));
            check($sformatf("cfg_done_%0d", i), 32'(ifc.done), 32'(vecs[i].exp_done));
            tick();
            check($sformatf("cfg_err_pulse_%0d", i), 32'(ifc.cfg_err), 0);
            if (!vecs[i].exp_err) begin
                m_fizz = int'(vecs[i].fizz);
                m_buzz = int'(vecs[i].buzz);
                m_max  = int'(vecs[i].max);
            end
            start_run();
            run_to_done(1'b1);
        end

        // Stop wins over the last-beat DONE transition
        start_run();
        wait_idx(255);
        ifc.stop = 1'b1;
        tick();
        ifc.stop = 1'b0;
        check("laststop_done", 32'(ifc.done), 0);
        check("laststop_busy", 32'(ifc.busy), 0);
        check("laststop_consumed", 32'(sb.size()), 0);
        sb.delete();

        // Reset mid-run restores defaults
        start_run();
        wait_idx(40);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", 32'(ifc.out_valid), 0);
        check("midrst_busy", 32'(ifc.busy), 0);
        check("midrst_index", 32'(ifc.out_index), 1);
        sb.delete();
        m_fizz = 3;
        m_buzz = 5;
        m_max  = 100;
        start_run();
        run_to_done(1'b1);

`ifdef FIZZBUZZ_PAUSE_EN
        // Pause at index 10 re-presents the same token
        start_run();
        wait_idx(10);
        ifc.out_ready = 1'b0;
        ifc.pause     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_valid", 32'(ifc.out_valid), 0);
            check("pause_busy", 32'(ifc.busy), 1);
        end
        ifc.pause = 1'b0;
        tick();
        check("resume_valid", 32'(ifc.out_valid), 1);
        check("resume_index", 32'(ifc.out_index), 10);
        check("resume_buzz", 32'(ifc.out_buzz), 1);
        ifc.out_ready = 1'b1;
        run_to_done(1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
